event_trig_gen: RTL and testbench

Synthesizable event initiator: the producing end of an OR-triggered event responder. Merges a programmable periodic tick and a software trigger pulse into a counted backlog of pending events. Issues the backlog one event at a time over a req/ack handshake, tagging each request with the sources that caused it. Sits upstream of the responder logic and replaces testbench-style `->event` / `#delay` triggering with clocked RTL.

---
 rtl/event_trig_gen_if.sv | 9 +
 rtl/event_trig_gen.sv | 137 +++++++++++++
 tb/tb_event_trig_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/event_trig_gen_if.sv
// Request/acknowledge channel between the event initiator (master) and the responder (slave).
interface event_trig_gen_if;
  logic       evt_req;
  logic       evt_ack;
  logic [1:0] evt_src;

  modport master (output evt_req, output evt_src, input evt_ack);
  modport slave  (input evt_req, input evt_src, output evt_ack);
endinterface

// File: rtl/event_trig_gen.sv
// Event initiator: merges a periodic tick and a software trigger into a counted backlog issued over req/ack.
// Optional request watchdog enabled by defining EVT_TRIG_TIMEOUT_EN.
module event_trig_gen #(
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned PEND_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PERIOD_W-1:0]   period,
  input  logic                  sw_trig,
  event_trig_gen_if.master      evt_if,
  output logic [PEND_W-1:0]     pend_cnt,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] tcnt_q, tcnt_d;
  logic [1:0]          src_acc_q, src_acc_d;
  logic [1:0]          evt_src_q, evt_src_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                evt_req_q, evt_req_d;

  logic                tick;
  logic                ev;
  logic [1:0]          cur_src;
  logic                ack_hit;
  logic                abandon;
  logic                dec;
  logic                ovf_set;

`ifdef EVT_TRIG_TIMEOUT_EN
  logic [8:0] wd_q, wd_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    tick      = 1'b0;
    tcnt_d    = '0;
    state_d   = state_q;
    evt_src_d = evt_src_q;
    pend_d    = pend_q;
    ovf_set   = 1'b0;
    abandon   = 1'b0;

    // Tick counter; the >= compare makes a reduced period take effect immediately
    if (en && (period != '0)) begin
      if (tcnt_q >= (period - PERIOD_W'(1))) tick = 1'b1;
      else                                   tcnt_d = tcnt_q + PERIOD_W'(1);
    end

    cur_src   = {en & sw_trig, tick};
    ev        = |cur_src;
    src_acc_d = src_acc_q | cur_src;

    ack_hit = (state_q == REQ) && evt_if.evt_ack;
`ifdef EVT_TRIG_TIMEOUT_EN
    wd_d = '0;
    if (state_q == REQ) begin
      wd_d    = wd_q + 9'd1;
      abandon = !evt_if.evt_ack && (wd_q == 9'd255);
    end
    timeout_d = abandon;
`endif
    dec = ack_hit | abandon;

    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d   = REQ;
          evt_src_d = src_acc_q | cur_src;
          // Sources seen this cycle belong to an event still queued behind this one
          src_acc_d = cur_src;
        end
      end
      REQ:     if (dec) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ev && !dec) begin
      if (pend_q == PEND_MAX) ovf_set = 1'b1;
      else                    pend_d  = pend_q + PEND_W'(1);
    end else if (dec && !ev) begin
      pend_d = pend_q - PEND_W'(1);
    end

    ovf_d     = ovf_set | (ovf_q & ~clr_ovf);
    evt_req_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      src_acc_q <= '0;
      evt_src_q <= '0;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      evt_req_q <= 1'b0;
`ifdef EVT_TRIG_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      src_acc_q <= src_acc_d;
      evt_src_q <= evt_src_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      evt_req_q <= evt_req_d;
`ifdef EVT_TRIG_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign evt_if.evt_req = evt_req_q;
  assign evt_if.evt_src = evt_src_q;
  assign pend_cnt       = pend_q;
  assign overflow       = ovf_q;
`ifdef EVT_TRIG_TIMEOUT_EN
  assign timeout        = timeout_q;
`else
  assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_event_trig_gen.sv
// Directed bench for event_trig_gen: periodic/software events, merge, saturation, reset, watchdog.
module tb_event_trig_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] period;
  logic       sw_trig;
  logic       clr_ovf;
  logic [3:0] pend_cnt;
  logic       overflow;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  event_trig_gen_if evt_if ();

  event_trig_gen #(.PERIOD_W(8), .PEND_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .period   (period),
    .sw_trig  (sw_trig),
    .evt_if   (evt_if),
    .pend_cnt (pend_cnt),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int   req_seen;
    int   last_c;
    int   max_p;
    logic prev;
    int   req_cycles;
    logic to_seen;

    rst = 1'b1; en = 1'b0; period = 8'd0; sw_trig = 1'b0; clr_ovf = 1'b0;
    evt_if.evt_ack = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_req",  32'(evt_if.evt_req), 32'd0);
    check("rst_src",  32'(evt_if.evt_src), 32'd0);
    check("rst_pend", 32'(pend_cnt),       32'd0);
    check("rst_ovf",  32'(overflow),       32'd0);
    check("rst_to",   32'(timeout),        32'd0);

    // Software trigger alone, periodic source disabled
    en = 1'b1; sw_trig = 1'b1;
    step(1);
    check("sw_pend_n",  32'(pend_cnt),       32'd1);
    check("sw_req_n",   32'(evt_if.evt_req), 32'd0);
    sw_trig = 1'b0;
    step(1);
    check("sw_req_n1",  32'(evt_if.evt_req), 32'd1);
    check("sw_src",     32'(evt_if.evt_src), 32'd2);
    evt_if.evt_ack = 1'b1;
    step(1);
    check("sw_req_ack", 32'(evt_if.evt_req), 32'd0);
    check("sw_pend_ack",32'(pend_cnt),       32'd0);
    step(1);
    check("stray_ack_req",  32'(evt_if.evt_req), 32'd0);
    check("stray_ack_pend", 32'(pend_cnt),       32'd0);
    evt_if.evt_ack = 1'b0;

    // Periodic source, period 10, ack one cycle after each request
    period = 8'd10; req_seen = 0; last_c = 0; max_p = 0; prev = 1'b0;
    for (int c = 0; c < 45; c++) begin
      step(1);
      if (int'(pend_cnt) > max_p) max_p = int'(pend_cnt);
      if (evt_if.evt_req && !prev) begin
        if (req_seen > 0) check("tick_spacing", 32'(c - last_c), 32'd10);
        else              check("tick_first",   32'(c),          32'd10);
        check("tick_src", 32'(evt_if.evt_src), 32'd1);
        last_c = c;
        req_seen++;
      end
      prev = evt_if.evt_req;
      evt_if.evt_ack = evt_if.evt_req;
    end
    check("tick_count", 32'(req_seen), 32'd4);
    check("tick_maxp",  32'(max_p),    32'd1);
    period = 8'd0; evt_if.evt_ack = 1'b0;
    step(3);
    check("tick_idle_pend", 32'(pend_cnt), 32'd0);

    // Tick and sw_trig coincide: one event, both source bits
    period = 8'd4;
    step(3);
    sw_trig = 1'b1;
    step(1);
    check("merge_pend", 32'(pend_cnt), 32'd1);
    sw_trig = 1'b0; period = 8'd0;
    step(1);
    check("merge_req",  32'(evt_if.evt_req), 32'd1);
    check("merge_src",  32'(evt_if.evt_src), 32'd3);
    check("merge_pend2",32'(pend_cnt),       32'd1);
    evt_if.evt_ack = 1'b1;
    step(1);
    evt_if.evt_ack = 1'b0;
    check("merge_drain", 32'(pend_cnt), 32'd0);
    step(2);

    // Saturation with no acks, then clear overflow and drain
    sw_trig = 1'b1;
    step(20);
    sw_trig = 1'b0;
    check("sat_pend", 32'(pend_cnt),       32'd15);
    check("sat_ovf",  32'(overflow),       32'd1);
    check("sat_req",  32'(evt_if.evt_req), 32'd1);
    check("sat_src",  32'(evt_if.evt_src), 32'd2);
    step(2);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    req_seen = 0; prev = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (evt_if.evt_req && !prev) req_seen++;
      prev = evt_if.evt_req;
      evt_if.evt_ack = evt_if.evt_req;
      step(1);
    end
    evt_if.evt_ack = 1'b0;
    check("drain_reqs", 32'(req_seen),        32'd15);
    check("drain_pend", 32'(pend_cnt),        32'd0);
    check("drain_req",  32'(evt_if.evt_req),  32'd0);

    // Reset mid-handshake with backlog of 3
    sw_trig = 1'b1;
    step(3);
    sw_trig = 1'b0;
    check("pre_rst_req",  32'(evt_if.evt_req), 32'd1);
    check("pre_rst_pend", 32'(pend_cnt),       32'd3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_req",  32'(evt_if.evt_req), 32'd0);
    check("mid_rst_pend", 32'(pend_cnt),       32'd0);
    check("mid_rst_src",  32'(evt_if.evt_src), 32'd0);
    check("mid_rst_ovf",  32'(overflow),       32'd0);
    step(5);
    check("post_rst_req", 32'(evt_if.evt_req), 32'd0);

    // Unacknowledged request: watchdog abandon or indefinite wait
    sw_trig = 1'b1;
    step(1);
    sw_trig = 1'b0;
    req_cycles = 0; to_seen = 1'b0;
`ifdef EVT_TRIG_TIMEOUT_EN
    for (int c = 0; c < 300 && !to_seen; c++) begin
      step(1);
      if (timeout) to_seen = 1'b1;
      else if (evt_if.evt_req) req_cycles++;
    end
    check("to_seen",    32'(to_seen),         32'd1);
    check("to_reqcyc",  32'(req_cycles),      32'd256);
    check("to_req",     32'(evt_if.evt_req),  32'd0);
    check("to_pend",    32'(pend_cnt),        32'd0);
    step(1);
    check("to_pulse",   32'(timeout),         32'd0);
`else
    for (int c = 0; c < 300; c++) begin
      step(1);
      if (evt_if.evt_req && !timeout) req_cycles++;
    end
    check("hold_reqcyc", 32'(req_cycles),     32'd300);
    check("hold_pend",   32'(pend_cnt),       32'd1);
    check("hold_to",     32'(timeout),        32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
